instruction_decode_stage: RTL and testbench

//  Registered decode stage between instruction fetch and the immediate generator, register file and ALU control.

---
 rtl/instruction_decode_stage_pkg.sv | 49 ++++
 rtl/instruction_decode_stage_field_extractor.sv | 77 +++++++
 rtl/instruction_decode_stage.sv | 128 ++++++++++++
 tb/tb_instruction_decode_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode constants: base opcodes, funct3/funct7 codes used by the
// legality checks, and the entry record held by the decode stage.
package instruction_decode_stage_pkg;

  localparam int XLEN_FIXED = 32;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OPCODE_LUI         = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC       = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL         = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR        = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH      = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD        = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE       = 7'b0100011;
  localparam logic [6:0] OPCODE_ITYPE       = 7'b0010011;
  localparam logic [6:0] OPCODE_RTYPE       = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE       = 7'b0001111;
  localparam logic [6:0] OPCODE_ENVIRONMENT = 7'b1110011;

  // funct3 codes that the legality checks care about
  localparam logic [2:0] FUNCT3_JALR    = 3'b000;
  localparam logic [2:0] FUNCT3_BR_RSV0 = 3'b010;
  localparam logic [2:0] FUNCT3_BR_RSV1 = 3'b011;
  localparam logic [2:0] FUNCT3_LD_RSV0 = 3'b011;
  localparam logic [2:0] FUNCT3_LD_RSV1 = 3'b110;
  localparam logic [2:0] FUNCT3_LD_RSV2 = 3'b111;
  localparam logic [2:0] FUNCT3_SW      = 3'b010;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  // funct7 codes
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // One decoded entry as held in the main or skid register
  typedef struct packed {
    logic [XLEN_FIXED-1:0] pc;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [6:0]            funct7;
    logic [XLEN_FIXED-1:0] raw_imm;
    logic                  illegal;
  } decode_entry_t;

endpackage

// File: rtl/instruction_decode_stage_field_extractor.sv
// Combinational field split of one instruction word: register/funct fields,
// the packed (not sign-extended) immediate, and the illegal-encoding flag.
module instruction_field_extractor
  import instruction_decode_stage_pkg::*;
#(
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] raw_imm,
  output logic        illegal
);

  logic        known_op;
  logic        bad_funct;
  logic [31:0] imm_sel;

  // Field split, per-format immediate packing and legality decode
  always_comb begin
    opcode    = inst[6:0];
    rd        = inst[11:7];
    funct3    = inst[14:12];
    rs1       = inst[19:15];
    rs2       = inst[24:20];
    funct7    = inst[31:25];
    known_op  = 1'b1;
    bad_funct = 1'b0;
    imm_sel   = 32'b0;
    case (inst[6:0])
      OPCODE_LUI, OPCODE_AUIPC: imm_sel = {inst[31:12], 12'b0};
      OPCODE_JAL: imm_sel = {11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPCODE_JALR: begin
        imm_sel   = {20'b0, inst[31:20]};
        bad_funct = (inst[14:12] != FUNCT3_JALR);
      end
      OPCODE_BRANCH: begin
        imm_sel   = {20'b0, inst[31], inst[7], inst[30:25], inst[11:8]};
        bad_funct = (inst[14:12] == FUNCT3_BR_RSV0) || (inst[14:12] == FUNCT3_BR_RSV1);
      end
      OPCODE_LOAD: begin
        imm_sel   = {20'b0, inst[31:20]};
        bad_funct = (inst[14:12] == FUNCT3_LD_RSV0) || (inst[14:12] == FUNCT3_LD_RSV1) ||
                    (inst[14:12] == FUNCT3_LD_RSV2);
      end
      OPCODE_STORE: begin
        imm_sel   = {20'b0, inst[31:25], inst[11:7]};
        bad_funct = (inst[14:12] > FUNCT3_SW);
      end
      OPCODE_ITYPE: begin
        imm_sel = {20'b0, inst[31:20]};
        // Shift-immediates reuse the upper imm bits as funct7
        if (inst[14:12] == FUNCT3_SLL) begin
          bad_funct = (inst[31:25] != FUNCT7_BASE);
        end else if (inst[14:12] == FUNCT3_SRL_SRA) begin
          bad_funct = (inst[31:25] != FUNCT7_BASE) && (inst[31:25] != FUNCT7_ALT);
        end
      end
      OPCODE_RTYPE: begin
        if (inst[31:25] == FUNCT7_ALT) begin
          bad_funct = (inst[14:12] != FUNCT3_ADD_SUB) && (inst[14:12] != FUNCT3_SRL_SRA);
        end else begin
          bad_funct = (inst[31:25] != FUNCT7_BASE);
        end
      end
      OPCODE_FENCE, OPCODE_ENVIRONMENT: imm_sel = {20'b0, inst[31:20]};
      default: known_op = 1'b0;
    endcase
    illegal = (inst[1:0] != 2'b11) || !known_op || ((CHECK_ILLEGAL != 0) && bad_funct);
    raw_imm = illegal ? 32'b0 : imm_sel;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main + skid).
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never waits on ready, and in_ready comes straight from a flop
// (it is ~skid_valid of the current cycle), so out_ready never reaches it.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_raw_imm,
  output logic            out_illegal
);

  decode_entry_t new_entry;
  decode_entry_t main_q;
  decode_entry_t skid_q;
  logic          main_valid_q;
  logic          skid_valid_q;
  logic          in_ready_q;
  logic          main_valid_d;
  logic          skid_valid_d;
  logic          load_main_new;
  logic          load_main_skid;
  logic          load_skid;
  logic          accept;
  logic          consume;

  instruction_field_extractor #(
    .CHECK_ILLEGAL(CHECK_ILLEGAL)
  ) u_extract (
    .inst    (in_inst),
    .opcode  (new_entry.opcode),
    .rd      (new_entry.rd),
    .funct3  (new_entry.funct3),
    .rs1     (new_entry.rs1),
    .rs2     (new_entry.rs2),
    .funct7  (new_entry.funct7),
    .raw_imm (new_entry.raw_imm),
    .illegal (new_entry.illegal)
  );

  assign new_entry.pc = in_pc;
  assign accept  = in_valid && in_ready_q;
  assign consume = main_valid_q && out_ready;

  // Next occupancy and which register loads; flush wins over any transfer
  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      // in_ready is low while skid is full, so no accept can coincide here
      load_main_skid = 1'b1;
      skid_valid_d   = 1'b0;
    end else if (!main_valid_q || consume) begin
      main_valid_d  = accept;
      load_main_new = accept;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      load_skid    = 1'b1;
    end
  end

  // Occupancy flags and the registered in_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  // Entry payload registers; main only changes when it is empty or consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_skid) begin
        main_q <= skid_q;
      end else if (load_main_new) begin
        main_q <= new_entry;
      end
      if (load_skid) begin
        skid_q <= new_entry;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_funct3  = main_q.funct3;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct7  = main_q.funct7;
  assign out_raw_imm = main_q.raw_imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: decode vector table plus hand-written
// stall, flush and mid-stream reset sequences with a pc scoreboard.
module tb_instruction_decode_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic [31:0] out_raw_imm;
  logic        out_illegal;

  instruction_decode_stage #(
    .XLEN(32),
    .CHECK_ILLEGAL(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_funct3  (out_funct3),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct7  (out_funct7),
    .out_raw_imm (out_raw_imm),
    .out_illegal (out_illegal)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q [$];
  logic [31:0] next_pc;
  int          n_acc;
  logic        rdy_seen;
  logic        vld_seen;

  // Scoreboard compare
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one table vector alone and check the registered decode one cycle later
  task automatic apply_vec(input int i);
    logic [31:0] pc;
    pc = 32'h1000 + 32'(i * 4);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_inst   = vecs[i].inst;
    in_pc     = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check($sformatf("vec%0d inst=%h", i, vecs[i].inst),
          {out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
           out_funct7, out_raw_imm, out_illegal},
          {1'b1, pc, vecs[i].opc, vecs[i].rd, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
           vecs[i].f7, vecs[i].imm, vecs[i].ill});
  endtask

  // One streaming cycle: drive at negedge, then score what transfers at the next edge
  task automatic step(input logic iv, input logic ordy, input logic fl);
    logic acc;
    logic con;
    logic [31:0] exp_pc;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pc     = next_pc;
    in_inst   = 32'h00000013;
    #1;
    acc      = iv && in_ready;
    con      = out_valid && ordy;
    rdy_seen = in_ready;
    vld_seen = out_valid;
    if (fl) begin
      exp_q.delete();
      if (acc) next_pc = next_pc + 32'd4;
    end else begin
      if (con) begin
        if (exp_q.size() == 0) begin
          check("unexpected output pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          exp_pc = exp_q.pop_front();
          check("stream pc order", out_pc, exp_pc);
        end
      end
      if (acc) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
        n_acc++;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, 1'b1, 1'b0);
    end
    check("drain empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0, 5'h1F, 7'h7F, 32'h00000FFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 7'h63, 5'h1D, 3'd0, 5'd0, 5'd0,  7'h7F, 32'h00000FFE, 1'b0};
    vecs[2]  = '{32'h001000EF, 7'h6F, 5'd1,  3'd0, 5'd0, 5'd1,  7'h00, 32'h00000800, 1'b0};
    vecs[3]  = '{32'h40000033, 7'h33, 5'd0,  3'd0, 5'd0, 5'd0,  7'h20, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h00000000, 7'h00, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[5]  = '{32'h0000707F, 7'h7F, 5'd0,  3'd7, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h4000F033, 7'h33, 5'd0,  3'd7, 5'd1, 5'd0,  7'h20, 32'h00000000, 1'b1};
    vecs[7]  = '{32'h123452B7, 7'h37, 5'd5,  3'd5, 5'd8, 5'd3,  7'h09, 32'h12345000, 1'b0};
    vecs[8]  = '{32'h0020A423, 7'h23, 5'd8,  3'd2, 5'd1, 5'd2,  7'h00, 32'h00000008, 1'b0};
    vecs[9]  = '{32'h00001067, 7'h67, 5'd0,  3'd1, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[10] = '{32'h4030D093, 7'h13, 5'd1,  3'd5, 5'd1, 5'd3,  7'h20, 32'h00000403, 1'b0};
    vecs[11] = '{32'h40009093, 7'h13, 5'd1,  3'd1, 5'd1, 5'd0,  7'h20, 32'h00000000, 1'b1};
    vecs[12] = '{32'h00003003, 7'h03, 5'd0,  3'd3, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[13] = '{32'h00002063, 7'h63, 5'd0,  3'd2, 5'd0, 5'd0,  7'h00, 32'h00000000, 1'b1};

    // Reset
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = 32'h0;
    in_inst   = 32'h0;
    next_pc   = 32'h0;
    n_acc     = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset data", {out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
                         out_funct7, out_raw_imm, out_illegal}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Decode table, back to back with consume
    for (int i = 0; i < NVEC; i++) apply_vec(i);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle after table", out_valid, 1'b0);

    // Stall: two accepts fill main+skid, then in_ready drops
    next_pc = 32'h0;
    n_acc   = 0;
    exp_q.delete();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("stall in_ready low", rdy_seen, 1'b0);
    check("stall accepted count", 32'(n_acc), 32'd2);
    check("stall head pc stable", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("throughput out_valid c%0d", i), vld_seen, 1'b1);
    end
    check("throughput in_ready", rdy_seen, 1'b1);
    drain();

    // Flush with both entries full and in_valid high
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("flush full out_valid", vld_seen, 1'b0);
    check("flush full in_ready", rdy_seen, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    drain();

    // Flush while an accept is possible: accept is discarded
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("flush accept dropped", vld_seen, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain();

    // Reset between edges with an entry held
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset in_ready", in_ready, 1'b1);
    check("async reset out_pc", out_pc, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    apply_vec(0);
    apply_vec(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
